// File: rtl/axi_to_bus.sv
`default_nettype none
//==============================================================================
// Module   : axi_to_bus
// Brief    : AXI3 32-bit slave that turns read/write bursts into MemoryBus word
//            requests, one AXI transaction in flight at a time.
//            Optional macro AXI_TO_BUS_SLVERR_EN: non-INCR / non-4-byte bursts
//            are answered with SLVERR and produce no bus traffic.
// Revision : 1.0 - initial release
//==============================================================================
module axi_to_bus #(
    parameter int ID_W       = 6,
    parameter int BUS_ADDR_W = 30,
    parameter int BUS_DATA_W = 24,
    parameter int BUS_ID_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // write address
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           awaddr,
    input  logic [ID_W-1:0]       awid,
    input  logic [3:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    // write data
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wlast,
    input  logic [ID_W-1:0]       wid,
    // write response
    output logic                  bvalid,
    input  logic                  bready,
    output logic [ID_W-1:0]       bid,
    output logic [1:0]            bresp,
    // read address
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [31:0]           araddr,
    input  logic [ID_W-1:0]       arid,
    input  logic [3:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    // read data
    output logic                  rvalid,
    input  logic                  rready,
    output logic [31:0]           rdata,
    output logic [ID_W-1:0]       rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    // MemoryBus request
    output logic                  msValid,
    input  logic                  msTaken,
    output logic                  msWrite,
    output logic [BUS_ADDR_W-1:0] msAddress,
    output logic [BUS_DATA_W-1:0] msData,
    output logic [BUS_ID_W-1:0]   msID,
    // MemoryBus response
    input  logic                  smValid,
    output logic                  smTaken,
    input  logic [BUS_DATA_W-1:0] smData,
    input  logic [BUS_ID_W-1:0]   smID
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_write  = 2'd1;
    localparam logic [1:0] c_st_wresp  = 2'd2;
    localparam logic [1:0] c_st_read   = 2'd3;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_last_rd;
    logic [BUS_ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]       r_id;
    logic [3:0]            r_len;
    logic [3:0]            r_wcnt;
    logic [4:0]            r_issued;
    logic [3:0]            r_returned;

    logic w_pick_rd;
    logic w_pick_wr;
    logic w_accept_wr;
    logic w_accept_rd;
    logic w_beat;
    logic w_issue;
    logic w_ret;
    logic w_issue_pend;
    logic w_err;

    // Round robin: on a tie the read wins only if the previous grant was a write.
    assign w_pick_rd    = arvalid && (!awvalid || !r_last_rd);
    assign w_pick_wr    = awvalid && !w_pick_rd;
    assign w_issue_pend = (r_issued <= {1'b0, r_len});

`ifdef AXI_TO_BUS_SLVERR_EN
    logic r_err;
    logic w_bad_aw;
    logic w_bad_ar;
    logic w_unused;

    assign w_bad_aw = (awburst != 2'b01) || (awsize != 3'b010);
    assign w_bad_ar = (arburst != 2'b01) || (arsize != 3'b010);
    assign w_err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept_wr || w_accept_rd) begin
            r_err <= w_accept_rd ? w_bad_ar : w_bad_aw;
        end
    end

    assign w_unused = ^{wstrb, wlast, awaddr[1:0], araddr[1:0],
                        wdata[31:BUS_DATA_W], smID[BUS_ID_W-1:ID_W]};
`else
    logic w_unused;

    assign w_err    = 1'b0;
    assign w_unused = ^{wstrb, wlast, awaddr[1:0], araddr[1:0],
                        wdata[31:BUS_DATA_W], smID[BUS_ID_W-1:ID_W],
                        awsize, awburst, arsize, arburst};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        awready      = 1'b0;
        arready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        bid          = '0;
        bresp        = c_resp_okay;
        rvalid       = 1'b0;
        rdata        = '0;
        rid          = '0;
        rresp        = c_resp_okay;
        rlast        = 1'b0;
        msValid      = 1'b0;
        msWrite      = 1'b0;
        msAddress    = r_addr;
        msData       = '0;
        msID         = BUS_ID_W'(r_id);
        smTaken      = 1'b1;
        w_accept_wr  = 1'b0;
        w_accept_rd  = 1'b0;
        w_beat       = 1'b0;
        w_issue      = 1'b0;
        w_ret        = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (!rst) begin
                    awready     = !w_pick_rd;
                    arready     = !w_pick_wr;
                    w_accept_wr = w_pick_wr;
                    w_accept_rd = w_pick_rd;
                    if (w_pick_wr) begin
                        w_state_next = c_st_write;
                    end else if (w_pick_rd) begin
                        w_state_next = c_st_read;
                    end
                end
            end

            c_st_write: begin
                if (w_err) begin
                    // Drain the data beats without touching the bus.
                    wready = 1'b1;
                    w_beat = wvalid;
                end else begin
                    msValid = wvalid;
                    msWrite = 1'b1;
                    msData  = wdata[BUS_DATA_W-1:0];
                    msID    = BUS_ID_W'(wid);
                    wready  = msTaken;
                    w_beat  = wvalid && msTaken;
                end
                if (w_beat && (r_wcnt == r_len)) begin
                    w_state_next = c_st_wresp;
                end
            end

            c_st_wresp: begin
                bvalid = 1'b1;
                bid    = r_id;
                bresp  = w_err ? c_resp_slverr : c_resp_okay;
                if (bready) begin
                    w_state_next = c_st_idle;
                end
            end

            c_st_read: begin
                rlast = (r_returned == r_len);
                if (w_err) begin
                    rvalid = 1'b1;
                    rid    = r_id;
                    rresp  = c_resp_slverr;
                    w_ret  = rready;
                end else begin
                    msValid = w_issue_pend;
                    w_issue = w_issue_pend && msTaken;
                    rvalid  = smValid;
                    rdata   = 32'(smData);
                    rid     = smID[ID_W-1:0];
                    smTaken = rready;
                    w_ret   = smValid && rready;
                end
                if (w_ret && rlast) begin
                    w_state_next = c_st_idle;
                end
            end

            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_rd  <= 1'b1;
            r_addr     <= '0;
            r_id       <= '0;
            r_len      <= '0;
            r_wcnt     <= '0;
            r_issued   <= '0;
            r_returned <= '0;
        end else if (w_accept_wr || w_accept_rd) begin
            r_last_rd  <= w_accept_rd;
            r_addr     <= w_accept_rd ? araddr[BUS_ADDR_W+1:2] : awaddr[BUS_ADDR_W+1:2];
            r_id       <= w_accept_rd ? arid : awid;
            r_len      <= w_accept_rd ? arlen : awlen;
            r_wcnt     <= '0;
            r_issued   <= '0;
            r_returned <= '0;
        end else begin
            // Address wraps modulo the bus address space; no 4 KB boundary logic.
            if (w_beat) begin
                r_addr <= r_addr + BUS_ADDR_W'(1);
                r_wcnt <= r_wcnt + 4'd1;
            end
            if (w_issue) begin
                r_addr   <= r_addr + BUS_ADDR_W'(1);
                r_issued <= r_issued + 5'd1;
            end
            if (w_ret) begin
                r_returned <= r_returned + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_to_bus.sv
`default_nettype none
//==============================================================================
// Module   : tb_axi_to_bus
// Brief    : Scoreboard bench for axi_to_bus with a random MemoryBus responder
//            and a word-level memory reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_axi_to_bus;

    localparam int ID_W = 6, BUS_ADDR_W = 30, BUS_DATA_W = 24, BUS_ID_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic awvalid = 0, awready; logic [31:0] awaddr = 0; logic [5:0] awid = 0;
    logic [3:0] awlen = 0; logic [2:0] awsize = 3'b010; logic [1:0] awburst = 2'b01;
    logic wvalid = 0, wready; logic [31:0] wdata = 0; logic [3:0] wstrb = 4'hf;
    logic wlast = 0; logic [5:0] wid = 0;
    logic bvalid, bready = 0; logic [5:0] bid; logic [1:0] bresp;
    logic arvalid = 0, arready; logic [31:0] araddr = 0; logic [5:0] arid = 0;
    logic [3:0] arlen = 0; logic [2:0] arsize = 3'b010; logic [1:0] arburst = 2'b01;
    logic rvalid, rready = 0; logic [31:0] rdata; logic [5:0] rid; logic [1:0] rresp; logic rlast;
    logic msValid, msTaken = 0, msWrite; logic [29:0] msAddress; logic [23:0] msData; logic [7:0] msID;
    logic smValid = 0, smTaken; logic [23:0] smData = 0; logic [7:0] smID = 0;

    axi_to_bus #(.ID_W(ID_W), .BUS_ADDR_W(BUS_ADDR_W), .BUS_DATA_W(BUS_DATA_W), .BUS_ID_W(BUS_ID_W)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
        .msValid(msValid), .msTaken(msTaken), .msWrite(msWrite), .msAddress(msAddress),
        .msData(msData), .msID(msID),
        .smValid(smValid), .smTaken(smTaken), .smData(smData), .smID(smID)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [29:0] addr; logic [23:0] data; logic [7:0] id; } bus_t;
    typedef struct { logic [31:0] data; logic [5:0] id; logic [1:0] resp; logic last; } r_t;
    typedef struct { logic [5:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [23:0] data; logic [7:0] id; } resp_t;

    bus_t  bus_exp[$];
    r_t    r_exp[$];
    b_t    b_exp[$];
    resp_t resp_q[$];
    logic [23:0] ref_mem [logic [29:0]];
    logic [23:0] bus_mem [logic [29:0]];

    int chk_cnt = 0;
    int pass_cnt = 0;
    int ms_mode = 2;      // 0 random, 1 toggle, 2 always taken
    int rr_mode = 1;      // 0 random, 1 always ready
    int rr_hold = 0;
    bit sm_took = 0;

    // monitor-side model state
    bit last_rd = 1;
    bit wr_active = 0, wr_err = 0, rd_active = 0, rd_err = 0;
    int wr_left = 0, rd_left = 0;
    bit prev_stall = 0;
    logic [31:0] prev_rdata = 0;
    bus_t be; r_t re; b_t bb;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic logic [23:0] dflt(input logic [29:0] a);
        return {a[11:0] ^ 12'h5a5, a[23:12]};
    endfunction

    function automatic bit err_of(input logic [1:0] burst, input logic [2:0] size);
`ifdef AXI_TO_BUS_SLVERR_EN
        return (burst != 2'b01) || (size != 3'b010);
`else
        return 1'b0;
`endif
    endfunction

    // Bus responder and scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            bus_exp.delete(); r_exp.delete(); b_exp.delete(); resp_q.delete();
            sm_took = 1; last_rd = 1; wr_active = 0; rd_active = 0; prev_stall = 0;
        end else begin
            if (smValid && smTaken) begin
                void'(resp_q.pop_front());
                sm_took = 1;
            end
            if (msValid && msTaken) begin
                if (bus_exp.size() == 0) begin
                    check("bus_unexpected", 0, {msWrite, msAddress}, 0);
                end else begin
                    be = bus_exp.pop_front();
                    check("bus_write_flag", msWrite == be.wr, msWrite, be.wr);
                    check("bus_addr", msAddress == be.addr, msAddress, be.addr);
                    check("bus_id", msID == be.id, msID, be.id);
                    if (be.wr) check("bus_data", msData == be.data, msData, be.data);
                end
                if (msWrite) bus_mem[msAddress] = msData;
                else resp_q.push_back('{data: bus_mem.exists(msAddress) ? bus_mem[msAddress] : dflt(msAddress), id: msID});
            end
            if (rvalid && rready) begin
                if (r_exp.size() == 0) begin
                    check("r_unexpected", 0, rdata, 0);
                end else begin
                    re = r_exp.pop_front();
                    check("r_data", rdata == re.data, rdata, re.data);
                    check("r_id", rid == re.id, rid, re.id);
                    check("r_resp", rresp == re.resp, rresp, re.resp);
                    check("r_last", rlast == re.last, rlast, re.last);
                end
            end
            if (bvalid && bready) begin
                if (b_exp.size() == 0) begin
                    check("b_unexpected", 0, bid, 0);
                end else begin
                    bb = b_exp.pop_front();
                    check("b_id", bid == bb.id, bid, bb.id);
                    check("b_resp", bresp == bb.resp, bresp, bb.resp);
                end
            end
            if (prev_stall) check("rdata_hold", rvalid && rdata == prev_rdata, {rvalid, rdata}, {1'b1, prev_rdata});
            prev_stall = rvalid && !rready;
            prev_rdata = rdata;

            if (wr_active) begin
                if (wr_err) begin
                    check("werr_no_bus", !msValid && wready, {msValid, wready}, 2'b01);
                end else begin
                    check("wready_mirror", wready == msTaken, wready, msTaken);
                    check("msvalid_mirror", msValid == wvalid, msValid, wvalid);
                end
                if (wvalid && wready) begin
                    wr_left--;
                    if (wr_left == 0) wr_active = 0;
                end
            end
            if (rd_active) begin
                if (rd_err) check("rerr_no_bus", !msValid, msValid, 0);
                else check("smtaken_mirror", smTaken == rready, smTaken, rready);
                if (rvalid && rready) begin
                    rd_left--;
                    if (rd_left == 0) rd_active = 0;
                end
            end

            if ((awvalid && awready) || (arvalid && arready)) begin
                check("grant_single", !(awvalid && awready && arvalid && arready), 1, 0);
                if (awvalid && arvalid)
                    check("grant_rr", (arvalid && arready) == !last_rd, arvalid && arready, !last_rd);
                last_rd = arvalid && arready;
                if (last_rd) begin
                    rd_active = 1; rd_left = arlen + 1; rd_err = err_of(arburst, arsize);
                end else begin
                    wr_active = 1; wr_left = awlen + 1; wr_err = err_of(awburst, awsize);
                end
            end
        end
    end

    // Bus-side and R-channel drivers
    always @(posedge clk) begin
        #1;
        case (ms_mode)
            0: msTaken = $urandom_range(0, 1);
            1: msTaken = !msTaken;
            default: msTaken = 1;
        endcase
        if (rr_hold > 0) begin
            rready = 0;
            rr_hold--;
        end else begin
            rready = (rr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        if (rst) begin
            smValid = 0;
        end else if (!smValid || sm_took) begin
            smValid = 0;
            if (resp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                smValid = 1;
                smData  = resp_q[0].data;
                smID    = resp_q[0].id;
            end
        end
        sm_took = 0;
    end

    task automatic axi_write(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input bit rnd, input logic [31:0] dbase, input int gap_pct);
        bit err;
        int n;
        logic [29:0] w;
        err = err_of(burst, size);
        @(posedge clk) #1;
        awvalid = 1; awaddr = addr; awid = id; awlen = len; awburst = burst; awsize = size;
        n = 0;
        forever begin
            @(negedge clk);
            if (awready || n > 300) break;
            n++;
        end
        @(posedge clk) #1;
        awvalid = 0;
        if (n > 300) begin
            check("aw_timeout", 0, n, 0);
            return;
        end
        b_exp.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        for (int i = 0; i <= len; i++) begin
            while ($urandom_range(0, 99) < gap_pct) @(posedge clk) #1;
            w = addr[31:2] + 30'(i);
            wvalid = 1; wid = id; wlast = (i == len);
            wdata = rnd ? $urandom : dbase + i;
            if (!err) begin
                bus_exp.push_back('{wr: 1'b1, addr: w, data: wdata[23:0], id: {2'b00, id}});
                ref_mem[w] = wdata[23:0];
            end
            n = 0;
            forever begin
                @(negedge clk);
                if (wready || n > 300) break;
                n++;
            end
            @(posedge clk) #1;
            wvalid = 0;
            if (n > 300) begin
                check("w_timeout", 0, i, len);
                return;
            end
        end
        n = 0;
        while (b_exp.size() != 0 && n < 100) begin
            bready = 1'($urandom_range(0, 1));
            @(posedge clk) #1;
            n++;
        end
        bready = 0;
        if (b_exp.size() != 0) check("b_timeout", 0, b_exp.size(), 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        bit err;
        int n;
        logic [29:0] w;
        logic [23:0] d;
        err = err_of(burst, size);
        @(posedge clk) #1;
        arvalid = 1; araddr = addr; arid = id; arlen = len; arburst = burst; arsize = size;
        n = 0;
        forever begin
            @(negedge clk);
            if (arready || n > 300) break;
            n++;
        end
        @(posedge clk) #1;
        arvalid = 0;
        if (n > 300) begin
            check("ar_timeout", 0, n, 0);
            return;
        end
        for (int i = 0; i <= len; i++) begin
            w = addr[31:2] + 30'(i);
            if (err) begin
                r_exp.push_back('{data: 32'h0, id: id, resp: 2'b10, last: (i == len)});
            end else begin
                d = ref_mem.exists(w) ? ref_mem[w] : dflt(w);
                bus_exp.push_back('{wr: 1'b0, addr: w, data: 24'h0, id: {2'b00, id}});
                r_exp.push_back('{data: {8'h00, d}, id: id, resp: 2'b00, last: (i == len)});
            end
        end
        n = 0;
        while (r_exp.size() != 0 && n < 1000) begin
            @(posedge clk) #1;
            n++;
        end
        if (r_exp.size() != 0) check("r_timeout", 0, r_exp.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valids", {awready, arready, wready, bvalid, rvalid, msValid} == 6'b0,
              {awready, arready, wready, bvalid, rvalid, msValid}, 0);
        check("rst_resp", {bresp, rresp, rlast} == 5'b0, {bresp, rresp, rlast}, 0);
        check("rst_data", {rdata, msAddress, msData} == '0, {rdata, msAddress}, 0);
        @(posedge clk) #1;
        rst = 0;

        // Single write, then a 4-beat read burst
        axi_write(32'h100, 6'd3, 4'd0, 2'b01, 3'b010, 0, 32'h00ABCDEF, 0);
        axi_read(32'h200, 6'd5, 4'd3, 2'b01, 3'b010);

        // Write burst with msTaken toggling
        ms_mode = 1;
        axi_write(32'h1000, 6'd7, 4'd7, 2'b01, 3'b010, 1, 0, 0);
        ms_mode = 2;

        // Simultaneous AW/AR twice, separated by a lone read
        fork
            axi_write(32'h2000, 6'd10, 4'd2, 2'b01, 3'b010, 1, 0, 0);
            axi_read(32'h1000, 6'd11, 4'd3, 2'b01, 3'b010);
        join
        axi_read(32'h100, 6'd12, 4'd0, 2'b01, 3'b010);
        fork
            axi_write(32'h2100, 6'd13, 4'd1, 2'b01, 3'b010, 1, 0, 0);
            axi_read(32'h2000, 6'd14, 4'd2, 2'b01, 3'b010);
        join

        // rready held low five cycles mid-burst
        fork
            axi_read(32'h3000, 6'd21, 4'd15, 2'b01, 3'b010);
            begin
                n = 0;
                while (!(r_exp.size() > 0 && r_exp.size() <= 12) && n < 300) begin
                    @(posedge clk) #1;
                    n++;
                end
                rr_hold = 5;
            end
        join

        // Address wrap at the top of the bus space
        axi_write(32'hFFFF_FFF8, 6'd30, 4'd3, 2'b01, 3'b010, 1, 0, 30);
        axi_read(32'hFFFF_FFF8, 6'd31, 4'd3, 2'b01, 3'b010);

        // Non-INCR read burst (SLVERR when the feature is enabled)
        axi_read(32'h400, 6'd33, 4'd1, 2'b10, 3'b010);

        // Random traffic
        ms_mode = 0; rr_mode = 0;
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [1:0] bu;
            logic [2:0] sz;
            a  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            bu = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
            sz = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
            if ($urandom_range(0, 1) == 1)
                axi_write(a, 6'($urandom), 4'($urandom), bu, sz, 1, 0, 25);
            else
                axi_read(a, 6'($urandom), 4'($urandom), bu, sz);
        end

        // Reset in the middle of a read burst
        fork
            axi_read(32'h5000, 6'd40, 4'd15, 2'b01, 3'b010);
            begin
                n = 0;
                while (!(r_exp.size() > 0 && r_exp.size() <= 13) && n < 300) begin
                    @(posedge clk) #1;
                    n++;
                end
                rst = 1;
                @(posedge clk);
                @(negedge clk);
                check("midrst_valids", {awready, arready, wready, bvalid, rvalid, msValid} == 6'b0,
                      {awready, arready, wready, bvalid, rvalid, msValid}, 0);
                check("midrst_data", {rdata, rresp, rlast, bresp} == '0, {rdata, rresp, rlast}, 0);
                @(posedge clk) #1;
                rst = 0;
            end
        join

        // Recovery after reset reads back the first write
        ms_mode = 2; rr_mode = 1;
        axi_read(32'h100, 6'd41, 4'd0, 2'b01, 3'b010);
        repeat (5) @(posedge clk);
        #1;
        check("end_queues", bus_exp.size() == 0 && r_exp.size() == 0 && b_exp.size() == 0,
              {bus_exp.size(), r_exp.size()}, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
